// File: rtl/cache_control.sv
// cache_control: miss handling and write sequencing for the LC-3b 2-way L1 cache.
// Decides when the merged CPU line, a victim writeback or a fill line reaches
// the way arrays, handshakes with the CPU and physical memory, and counts misses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | serve hits in the request cycle; a miss starts a line fetch
// WRITEBACK | dirty victim line going out to pmem, wait for pmem_resp
// ALLOCATE  | fill line coming in from pmem, installed into lru way on pmem_resp
module cache_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    input  logic        pmem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic        hit0,
    input  logic        hit1,
    input  logic        dirty0,
    input  logic        dirty1,
    input  logic        lru,
    output logic        load_way0,
    output logic        load_way1,
    output logic        dirty_in,
    output logic        load_lru,
    output logic        lru_in,
    output logic        datain_sel,
    output logic        pmem_addr_sel,
    output logic [15:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] miss_count_q, miss_count_d;

    logic request;
    logic is_write;
    logic hit;
    logic hitway;
    logic victim_dirty;

    // A simultaneous read and write is handled as a write.
    assign request      = mem_read | mem_write;
    assign is_write     = mem_write;
    assign hit          = hit0 | hit1;
    // hit0 takes priority if both ways report a hit.
    assign hitway       = ~hit0;
    assign victim_dirty = lru ? dirty1 : dirty0;
    assign miss_count   = miss_count_q;

    // State and miss counter registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            miss_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Next-state and miss-count logic; the counter moves only on the IDLE miss cycle.
    always_comb begin
        state_d      = state_q;
        miss_count_d = miss_count_q;
        case (state_q)
            IDLE: begin
                if (request && !hit) begin
                    if (miss_count_q != 16'hFFFF) begin
                        miss_count_d = miss_count_q + 16'd1;
                    end
                    state_d = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        load_way0     = 1'b0;
        load_way1     = 1'b0;
        dirty_in      = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        datain_sel    = 1'b0;
        pmem_addr_sel = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (request && hit) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_in   = ~hitway;
                        if (is_write) begin
                            load_way0  = ~hitway;
                            load_way1  = hitway;
                            datain_sel = 1'b1;
                            dirty_in   = 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_way0 = ~lru;
                        load_way1 = lru;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
